// File: rtl/bram_mp_rnw1.sv
// bram_mp_rnw1: block RAM with one byte-masked write port and NRP read ports
// sharing a common read enable. Reads are registered (1-cycle latency) and the
// array itself is read-first; optional write-to-read forwarding is applied at
// the output stage from a registered hit flag plus the captured write data and
// byte enables. An optional post-reset clear zeroes every entry.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_wren       write enable
//   i_wben       byte-lane write enables (bit k -> data bits [8k+7:8k])
//   i_waddr      write address
//   i_wdata      write data
//   i_rden       read enable shared by all read ports
//   i_raddr      read addresses, port p at [p*ADW +: ADW]
//   o_rdata      read data, port p at [p*DTW +: DTW]
//   o_rvalid     o_rdata was updated by a read accepted in the previous cycle
//   o_init_busy  clear in progress; all requests are ignored while high
module bram_mp_rnw1 #(
  parameter int DTW       = 32,
  parameter int DPT       = 32,
  parameter int NRP       = 2,
  parameter int WR_BYPASS = 1,
  parameter int INIT_CLR  = 1,
  localparam int ADW      = $clog2(DPT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wren,
  input  logic [DTW/8-1:0]     i_wben,
  input  logic [ADW-1:0]       i_waddr,
  input  logic [DTW-1:0]       i_wdata,
  input  logic                 i_rden,
  input  logic [NRP*ADW-1:0]   i_raddr,
  output logic [NRP*DTW-1:0]   o_rdata,
  output logic                 o_rvalid,
  output logic                 o_init_busy
);

  localparam int NBL    = DTW / 8;
  localparam int DPT_2N = 2 ** ADW;
  localparam logic [ADW-1:0] CNT_LAST = ADW'(DPT_2N - 1);

  typedef enum logic {CLR, RDY} state_t;
  localparam state_t RST_STATE = (INIT_CLR != 0) ? CLR : RDY;

  state_t         state;
  logic [ADW-1:0] clr_cnt;

  (* ram_style = "block" *) logic [DTW-1:0] ram [DPT_2N];

  logic [ADW-1:0] raddr_p0 [NRP];
  logic           clr_we_p0;
  logic           wr_acc_p0;
  logic           rd_acc_p0;

  logic [DTW-1:0] raw_p1 [NRP];
  logic [NRP-1:0] hit_p1;
  logic [DTW-1:0] wdata_p1;
  logic [NBL-1:0] wben_p1;
  logic           vld_p1;
  logic           data_ok_p1;

  // ---- stage p0: request acceptance and controller ----
  always_comb begin
    for (int p = 0; p < NRP; p++) raddr_p0[p] = i_raddr[p*ADW +: ADW];
  end

  assign o_init_busy = (state == CLR);
  // rst is folded in so nothing reaches the array while reset is held
  assign clr_we_p0   = o_init_busy & ~rst;
  assign wr_acc_p0   = i_wren & ~o_init_busy & ~rst;
  assign rd_acc_p0   = i_rden & ~o_init_busy & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else if (state == CLR) begin
      clr_cnt <= clr_cnt + ADW'(1);
      if (clr_cnt == CNT_LAST) state <= RDY;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we_p0) begin
      ram[clr_cnt] <= '0;
    end else if (wr_acc_p0) begin
      for (int k = 0; k < NBL; k++)
        if (i_wben[k]) ram[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
    end
  end

  // ---- stage p1: read-first array output plus forwarding capture ----
  always_ff @(posedge clk) begin
    if (rd_acc_p0)
      for (int p = 0; p < NRP; p++) raw_p1[p] <= ram[raddr_p0[p]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1     <= '0;
      wdata_p1   <= '0;
      wben_p1    <= '0;
      vld_p1     <= 1'b0;
      data_ok_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc_p0;
      if (rd_acc_p0) begin
        data_ok_p1 <= 1'b1;
        wdata_p1   <= i_wdata;
        wben_p1    <= wr_acc_p0 ? i_wben : '0;
        for (int p = 0; p < NRP; p++)
          hit_p1[p] <= (WR_BYPASS != 0) && wr_acc_p0 && (raddr_p0[p] == i_waddr);
      end
    end
  end

  // raw_p1 has no reset, so data_ok_p1 keeps o_rdata at zero until the first
  // read after reset; all merge inputs only change on an accepted read, so the
  // output holds otherwise.
  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int k = 0; k < NBL; k++) begin
        if (hit_p1[p] && wben_p1[k])
          o_rdata[p*DTW + 8*k +: 8] = wdata_p1[8*k +: 8];
        else
          o_rdata[p*DTW + 8*k +: 8] = raw_p1[p][8*k +: 8];
      end
      if (!data_ok_p1) o_rdata[p*DTW +: DTW] = '0;
    end
  end

  assign o_rvalid = vld_p1;

endmodule
